// File: rtl/bp_pkg.sv
// Shared constants and types for the branch predictor: table geometry,
// 2-bit counter encodings and the per-entry record.
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int IDX_W      = 4;   // PC[5:2]
  localparam int TAG_W      = 26;  // PC[31:6]
  localparam int TGT_W      = 30;  // target[31:2]

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
    logic [TGT_W-1:0] target;
  } bp_entry_t;

  localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, ctr: CTR_WNT, target: '0};

  // The counter MSB is the taken/not-taken prediction.
  function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic (purely combinational).
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Step toward taken or not-taken, holding at the two extremes.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit counters.
// Fetch looks up combinationally; EX resolves, trains the table and raises
// a same-cycle mispredict/redirect. Optional statistics under BP_STATS_EN.
//
// EX interface: ex_valid is a valid-only strobe with no ready; every cycle
// with ex_valid=1 is exactly one resolved branch and is always accepted.
module branch_predictor
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  bp_entry_t        table_q [BP_ENTRIES];
  bp_entry_t        entry_d;
  logic             wr_en;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  bp_entry_t        if_entry, ex_entry;
  logic             ex_hit;
  logic [1:0]       ctr_nxt;

  // Word-alignment bits are not part of index, tag or stored target.
  logic             unused_low_bits;
  assign unused_low_bits = ^{if_pc[1:0], ex_pc[1:0], ex_target[1:0]};

  assign if_idx   = if_pc[5:2];
  assign if_tag   = if_pc[31:6];
  assign ex_idx   = ex_pc[5:2];
  assign ex_tag   = ex_pc[31:6];
  assign if_entry = table_q[if_idx];
  assign ex_entry = table_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  bp_sat_counter u_ctr (
    .ctr_i   (ex_entry.ctr),
    .taken_i (ex_taken),
    .ctr_o   (ctr_nxt)
  );

  // Fetch lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_taken  = if_entry.valid && (if_entry.tag == if_tag) && ctr_predicts_taken(if_entry.ctr);
    pred_target = pred_taken ? {if_entry.target, 2'b00} : 32'd0;
  end

  // Training: hits adjust the counter (and target when taken); taken misses allocate.
  always_comb begin
    entry_d = ex_entry;
    wr_en   = 1'b0;
    if (ex_valid) begin
      if (ex_hit) begin
        wr_en       = 1'b1;
        entry_d.ctr = ctr_nxt;
        if (ex_taken) entry_d.target = ex_target[31:2];
      end else if (ex_taken) begin
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = ex_tag;
        entry_d.ctr    = CTR_WT;
        entry_d.target = ex_target[31:2];
      end
    end
  end

  // Table storage; an asynchronous reset drops any update in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_ENTRIES; i++) table_q[i] <= ENTRY_RST;
    end else if (wr_en) begin
      table_q[ex_idx] <= entry_d;
    end
  end

  // Mispredict on direction mismatch or on a taken branch with the wrong target.
  always_comb begin
    mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    redirect_pc = 32'd0;
    if (mispredict) redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Wrapping event counters for resolved branches and mispredicts.
  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, ex_valid};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
